cordic_hyp_iter: RTL and testbench



---
 rtl/cordic_hyp_pkg.sv | 51 +++++
 rtl/cordic_hyp_step.sv | 32 +++
 rtl/cordic_hyp_iter.sv | 113 +++++++++++
 tb/tb_cordic_hyp_iter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_hyp_pkg.sv
// Shared constants and helpers for the folded hyperbolic CORDIC engine.
package cordic_hyp_pkg;

    localparam int unsigned TAB_LEN = 30;
    localparam int unsigned SHIFT_W = 5;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // atanh(2^-i) in Q2.30; for i >= 10 the cubic term is below half an LSB.
    function automatic logic [31:0] atanh_tab(input int unsigned i);
        logic [31:0] v;
        case (i)
            1:       v = 32'd589812981;
            2:       v = 32'd274247418;
            3:       v = 32'd134923406;
            4:       v = 32'd67196451;
            5:       v = 32'd33565361;
            6:       v = 32'd16778582;
            7:       v = 32'd8388779;
            8:       v = 32'd4194325;
            9:       v = 32'd2097155;
            default: v = (i >= 10 && i <= TAB_LEN) ? (32'd1 << (30 - i)) : 32'd0;
        endcase
        return v;
    endfunction

    // Shift for step k: 1,2,3,4,4,5,...,13,13,14,...
    function automatic logic [SHIFT_W-1:0] shift_of(input int unsigned k);
        int unsigned s;
        if (k < 4)       s = k + 1;
        else if (k < 14) s = k;
        else             s = k - 1;
        return SHIFT_W'(s);
    endfunction

    // Table entry rounded to nearest at an aw-bit Q2.(aw-2) angle.
    function automatic logic [31:0] atanh_q(input int unsigned s, input int unsigned aw);
        logic [32:0] t;
        t = {1'b0, atanh_tab(s)};
        if (aw < 32) t = (t + (33'd1 << (31 - aw))) >> (32 - aw);
        return t[31:0];
    endfunction

endpackage

// File: rtl/cordic_hyp_step.sv
// One combinational hyperbolic micro-rotation, shared across all iterations.
module cordic_hyp_step
    import cordic_hyp_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ANGLE_W = 16
) (
    input  logic signed [WIDTH-1:0]   i_x,
    input  logic signed [WIDTH-1:0]   i_y,
    input  logic signed [ANGLE_W-1:0] i_z,
    input  logic [SHIFT_W-1:0]        i_s,
    input  logic signed [ANGLE_W-1:0] i_atanh,
    input  logic                      i_mode,
    output logic signed [WIDTH-1:0]   o_x,
    output logic signed [WIDTH-1:0]   o_y,
    output logic signed [ANGLE_W-1:0] o_z
);

    logic                    w_pos;
    logic signed [WIDTH-1:0] w_xs;
    logic signed [WIDTH-1:0] w_ys;

    // d = +1: rotation when z >= 0, vectoring when y < 0
    assign w_pos = (i_mode == MODE_VEC) ? i_y[WIDTH-1] : ~i_z[ANGLE_W-1];
    assign w_xs  = i_x >>> i_s;
    assign w_ys  = i_y >>> i_s;

    assign o_x = w_pos ? (i_x + w_ys)    : (i_x - w_ys);
    assign o_y = w_pos ? (i_y + w_xs)    : (i_y - w_xs);
    assign o_z = w_pos ? (i_z - i_atanh) : (i_z + i_atanh);

endmodule

// File: rtl/cordic_hyp_iter.sv
// Folded hyperbolic CORDIC: a single step unit reused for ITER cycles per operand.
module cordic_hyp_iter
    import cordic_hyp_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ANGLE_W = 16,
    parameter int unsigned ITER    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic signed [WIDTH-1:0]   y_in,
    input  logic signed [ANGLE_W-1:0] z_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   x_out,
    output logic signed [WIDTH-1:0]   y_out,
    output logic signed [ANGLE_W-1:0] z_out,
    output logic                      busy
);

    localparam int unsigned      CNT_W     = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      r_mode, w_mode_nxt;
    logic signed [WIDTH-1:0]   r_x, r_y, w_x_nxt, w_y_nxt;
    logic signed [ANGLE_W-1:0] r_z, w_z_nxt;
    logic signed [WIDTH-1:0]   w_step_x, w_step_y;
    logic signed [ANGLE_W-1:0] w_step_z, w_atanh;
    logic [SHIFT_W-1:0]        w_shift;

    assign w_shift = shift_of(32'(r_cnt));
    assign w_atanh = ANGLE_W'(atanh_q(32'(w_shift), ANGLE_W));

    cordic_hyp_step #(
        .WIDTH   (WIDTH),
        .ANGLE_W (ANGLE_W)
    ) u_step (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_s     (w_shift),
        .i_atanh (w_atanh),
        .i_mode  (r_mode),
        .o_x     (w_step_x),
        .o_y     (w_step_y),
        .o_z     (w_step_z)
    );

    assign in_ready  = (r_state == ST_IDLE) && !reset;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign z_out     = r_z;

    // Next-state and datapath select
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_z_nxt     = r_z;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_mode_nxt  = mode;
                    w_x_nxt     = x_in;
                    w_y_nxt     = y_in;
                    w_z_nxt     = z_in;
                end
            end
            ST_RUN: begin
                w_x_nxt   = w_step_x;
                w_y_nxt   = w_step_y;
                w_z_nxt   = w_step_z;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_STEP) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_ROT;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_z     <= w_z_nxt;
        end
    end

endmodule

// File: tb/tb_cordic_hyp_iter.sv
// Scoreboard bench for cordic_hyp_iter (ITER=16 main instance, ITER=5 schedule instance).
module tb_cordic_hyp_iter;

    localparam int W   = 16;
    localparam int AW  = 16;
    localparam int IT  = 16;
    localparam int IT5 = 5;
    localparam int TOL = 8;

    typedef struct {
        logic signed [W-1:0]  x;
        logic signed [W-1:0]  y;
        logic signed [AW-1:0] z;
    } res_t;

    logic clk;
    logic reset, in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic signed [W-1:0]  x_in, y_in, x_out, y_out;
    logic signed [AW-1:0] z_in, z_out;
    logic reset5, in_valid5, in_ready5, mode5, out_valid5, out_ready5, busy5;
    logic signed [W-1:0]  x_in5, y_in5, x_out5, y_out5;
    logic signed [AW-1:0] z_in5, z_out5;

    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   sched [40];
    res_t exp_q [$];

    cordic_hyp_iter #(.WIDTH(W), .ANGLE_W(AW), .ITER(IT)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy)
    );

    cordic_hyp_iter #(.WIDTH(W), .ANGLE_W(AW), .ITER(IT5)) u_dut5 (
        .clk(clk), .reset(reset5), .in_valid(in_valid5), .in_ready(in_ready5), .mode(mode5),
        .x_in(x_in5), .y_in(y_in5), .z_in(z_in5), .out_valid(out_valid5), .out_ready(out_ready5),
        .x_out(x_out5), .y_out(y_out5), .z_out(z_out5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int wrap(input int v, input int bits);
        return (v << (32 - bits)) >>> (32 - bits);
    endfunction

    // atanh(2^-s) rounded to the angle LSB, from first principles
    function automatic int atanh_lsb(input int s);
        real v, a;
        v = 1.0;
        for (int i = 0; i < s; i++) v = v / 2.0;
        a = 0.5 * $ln((1.0 + v) / (1.0 - v));
        return $rtoi(a * real'(1 << (AW - 2)) + 0.5);
    endfunction

    function automatic void ref_step(input logic m, input int s, input int x, input int y,
                                     input int z, output int xn, output int yn, output int zn);
        bit pos;
        pos = m ? (y < 0) : (z >= 0);
        if (pos) begin
            xn = x + (y >>> s);
            yn = y + (x >>> s);
            zn = z - atanh_lsb(s);
        end else begin
            xn = x - (y >>> s);
            yn = y - (x >>> s);
            zn = z + atanh_lsb(s);
        end
        xn = wrap(xn, W);
        yn = wrap(yn, W);
        zn = wrap(zn, AW);
    endfunction

    function automatic res_t ref_model(input logic m, input int x0, input int y0, input int z0,
                                       input int n);
        int   x, y, z, xn, yn, zn;
        res_t r;
        x = x0;
        y = y0;
        z = z0;
        for (int k = 0; k < n; k++) begin
            ref_step(m, sched[k], x, y, z, xn, yn, zn);
            x = xn;
            y = yn;
            z = zn;
        end
        r.x = W'(x);
        r.y = W'(y);
        r.z = AW'(z);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input int x, input int y, input int z);
        mode     = m;
        x_in     = W'(x);
        y_in     = W'(y);
        z_in     = AW'(z);
        in_valid = 1'b1;
        exp_q.push_back(ref_model(m, x, y, z, IT));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset5 = 1'b1;
        in_valid = 1'b0; in_valid5 = 1'b0; out_ready = 1'b0; out_ready5 = 1'b0;
        mode = 1'b0; mode5 = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; x_in5 = '0; y_in5 = '0; z_in5 = '0;
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset = 1'b0; reset5 = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        end
        n_cmp++;
        if ({x_out, y_out, z_out} !== 48'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %0d %0d %0d want 0 0 0", x_out, y_out, z_out);
        end
        n_cmp++;
        if ({in_ready5, out_valid5, busy5} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_flags5: got %b want 100", {in_ready5, out_valid5, busy5});
        end
    endtask

    task automatic test_rotation();
        int   lat;
        res_t e;
        issue(1'b0, 16384, 0, 8192);
        wait_valid(lat);
        n_cmp++;
        if (lat !== IT) begin
            n_bad++;
            $display("FAIL rot_latency: got %0d want %0d", lat, IT);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
            n_bad++;
            $display("FAIL rot_exact: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, e.x, e.y, e.z);
        end
        n_cmp++;
        if (iabs(x_out - 15301) > TOL || iabs(y_out - 7071) > TOL || iabs(z_out) > TOL) begin
            n_bad++;
            $display("FAIL rot_ideal: got %0d %0d %0d want ~15301 ~7071 ~0", x_out, y_out, z_out);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL rot_release: got rdy/vld=%b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_vectoring();
        int   lat;
        res_t e;
        issue(1'b1, 16384, 8192, 0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== IT) begin
            n_bad++;
            $display("FAIL vec_latency: got %0d want %0d", lat, IT);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
            n_bad++;
            $display("FAIL vec_exact: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, e.x, e.y, e.z);
        end
        n_cmp++;
        if (iabs(x_out - 11751) > TOL || iabs(y_out) > TOL || iabs(z_out - 9000) > TOL) begin
            n_bad++;
            $display("FAIL vec_ideal: got %0d %0d %0d want ~11751 ~0 ~9000", x_out, y_out, z_out);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_handshake();
        int                   lat;
        res_t                 e;
        logic [3*W-1:0]       snap;
        issue(1'b0, 12000, 2000, -6000);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            mode     = ~mode;
            x_in     = W'($urandom);
            y_in     = W'($urandom);
            z_in     = AW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL hs_run_flags: got busy/rdy/vld=%b want 100", {busy, in_ready, out_valid});
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== IT - 6) begin
            n_bad++;
            $display("FAIL hs_latency: got %0d want %0d", lat + 6, IT);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
            n_bad++;
            $display("FAIL hs_exact: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, e.x, e.y, e.z);
        end
        snap = {e.x, e.y, e.z};
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({out_valid, in_ready, busy} !== 3'b101 || {x_out, y_out, z_out} !== snap) begin
                n_bad++;
                $display("FAIL hs_hold[%0d]: got vld/rdy/busy=%b out=%0d %0d %0d want 101 stable",
                         i, {out_valid, in_ready, busy}, x_out, y_out, z_out);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL hs_release: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        end
        tick();
        tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL hs_no_ghost: got vld/busy=%b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        res_t e;
        issue(1'b1, 16384, 4000, 0);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b000 || {x_out, y_out, z_out} !== 48'd0) begin
            n_bad++;
            $display("FAIL midrst_abort: got vld/busy/rdy=%b out=%0d %0d %0d want 000 0 0 0",
                     {out_valid, busy, in_ready}, x_out, y_out, z_out);
        end
        reset = 1'b0;
        exp_q.delete();
        issue(1'b0, 16384, 0, -12000);
        wait_valid(lat);
        n_cmp++;
        if (lat !== IT) begin
            n_bad++;
            $display("FAIL midrst_latency: got %0d want %0d", lat, IT);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
            n_bad++;
            $display("FAIL midrst_exact: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, e.x, e.y, e.z);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_with_valid();
        mode = 1'b0; x_in = 16'sd16384; y_in = '0; z_in = 16'sd4096;
        in_valid = 1'b1;
        reset    = 1'b1;
        tick();
        n_cmp++;
        if ({busy, in_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstvld_during: got busy/rdy=%b want 00", {busy, in_ready});
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL rstvld_none_taken: got busy/vld/rdy=%b want 001", {busy, out_valid, in_ready});
        end
    endtask

    task automatic test_schedule();
        int   x, y, z, xn, yn, zn;
        logic m;
        for (int t = 0; t < 2; t++) begin
            m  = t[0];
            x  = m ? 15000 : 16384;
            y  = m ? 7000  : 0;
            z  = m ? 0     : -9000;
            mode5 = m; x_in5 = W'(x); y_in5 = W'(y); z_in5 = AW'(z);
            in_valid5 = 1'b1;
            tick();
            in_valid5 = 1'b0;
            for (int k = 0; k < IT5; k++) begin
                n_cmp++;
                if (out_valid5 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sched_early[%0d/%0d]: got out_valid=%b want 0", t, k, out_valid5);
                end
                ref_step(m, sched[k], x, y, z, xn, yn, zn);
                x = xn;
                y = yn;
                z = zn;
                tick();
                n_cmp++;
                if ({x_out5, y_out5, z_out5} !== {W'(x), W'(y), AW'(z)}) begin
                    n_bad++;
                    $display("FAIL sched_step[%0d/%0d] s=%0d: got %0d %0d %0d want %0d %0d %0d",
                             t, k, sched[k], x_out5, y_out5, z_out5, x, y, z);
                end
            end
            n_cmp++;
            if (out_valid5 !== 1'b1) begin
                n_bad++;
                $display("FAIL sched_done[%0d]: got out_valid=%b want 1", t, out_valid5);
            end
            out_ready5 = 1'b1;
            tick();
            out_ready5 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic mm [4];
        int   xs [4];
        int   ys [4];
        int   zs [4];
        int   sent, got, last_cyc;
        logic accepted;
        res_t e;
        mm[0] = 1'b0; xs[0] = 16384; ys[0] = 0;                        zs[0] = -8192;
        mm[1] = 1'b1; xs[1] = 16384; ys[1] = -8192;                    zs[1] = 0;
        mm[2] = 1'b0; xs[2] = 9830;  ys[2] = 3277;                     zs[2] = 18317;
        mm[3] = 1'b1; xs[3] = 20000; ys[3] = int'($urandom_range(0, 8000)); zs[3] = 100;
        sent = 0; got = 0; last_cyc = -1;
        out_ready = 1'b1;
        mode = mm[0]; x_in = W'(xs[0]); y_in = W'(ys[0]); z_in = AW'(zs[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 200 && got < 4; c++) begin
            accepted = in_valid && in_ready;
            if (accepted) exp_q.push_back(ref_model(mm[sent], xs[sent], ys[sent], zs[sent], IT));
            tick();
            if (accepted) begin
                sent++;
                if (sent < 4) begin
                    mode = mm[sent]; x_in = W'(xs[sent]); y_in = W'(ys[sent]); z_in = AW'(zs[sent]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
                    n_bad++;
                    $display("FAIL b2b_exact[%0d]: got %0d %0d %0d want %0d %0d %0d",
                             got, x_out, y_out, z_out, e.x, e.y, e.z);
                end
                if (last_cyc >= 0) begin
                    n_cmp++;
                    if (cyc - last_cyc !== IT + 2) begin
                        n_bad++;
                        $display("FAIL b2b_cadence[%0d]: got %0d cycles want %0d", got, cyc - last_cyc, IT + 2);
                    end
                end
                last_cyc = cyc;
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (got !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results want 4", got);
        end
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        n     = 0;
        // shift schedule with the 4 and 13 repeats
        for (int v = 1; n < 40; v++) begin
            sched[n] = v;
            n++;
            if ((v == 4 || v == 13) && n < 40) begin
                sched[n] = v;
                n++;
            end
        end
        test_reset();
        test_rotation();
        test_vectoring();
        test_handshake();
        test_reset_mid();
        test_reset_with_valid();
        test_schedule();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
